// File: rtl/digitallock_key_poller_if.sv
// Avalon-MM read bus toward the KEY PIO together with the key-event ready/valid stream.
interface digitallock_key_poller_if;
   logic [1:0]  avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        evt_valid;
   logic [1:0]  evt_key;
   logic        evt_ready;

   modport master (
      output avm_address, avm_read, evt_valid, evt_key,
      input  avm_waitrequest, avm_readdata, evt_ready
   );

   modport slave (
      input  avm_address, avm_read, evt_valid, evt_key,
      output avm_waitrequest, avm_readdata, evt_ready
   );
endinterface

// File: rtl/digitallock_key_poller.sv
// Polls the KEY PIO over Avalon-MM, debounces the four active-low keys and queues
// one event per debounced press for the lock sequencer.
module digitallock_key_poller #(
   parameter int POLL_DIV     = 50000,
   parameter int STABLE_POLLS = 3,
   parameter int FIFO_DEPTH   = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      poll_en,
   digitallock_key_poller_if.master  bus,
   output logic [3:0]                key_state,
   output logic                      overflow,
   input  logic                      overflow_clr
);

   localparam int DIV_W = $clog2(POLL_DIV);
   localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1'b1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
   localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1'b1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [3:0]       STABLE   = 4'(STABLE_POLLS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t                         state_r, state_s;
   logic [DIV_W-1:0]               div_cnt_r, div_cnt_s;
   logic [LAT_W-1:0]               lat_cnt_r, lat_cnt_s;
   logic                           avm_read_r;
   logic                           sample_s;
   logic [3:0]                     cand_r, cand_s;
   logic [3:0][3:0]                stab_r, stab_s;
   logic [3:0]                     deb_r, deb_s;
   logic [3:0]                     key_state_r;
   logic [3:0]                     pending_r, pending_s;
   logic [3:0]                     press_s, push_mask_s;
   logic [1:0]                     push_idx_s;
   logic                           push_s, pop_s, lost_s;
   logic                           overflow_r;
   logic [FIFO_DEPTH-1:0][1:0]     mem_r;
   logic [PTR_W-1:0]               wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0]               fifo_cnt_r;
   logic                           unused_bits_s;

   function automatic logic [1:0] lowest_index(input logic [3:0] v);
      logic [1:0] idx;
      if (v[0]) begin
         idx = 2'd0;
      end else if (v[1]) begin
         idx = 2'd1;
      end else if (v[2]) begin
         idx = 2'd2;
      end else begin
         idx = 2'd3;
      end
      return idx;
   endfunction

   // Poll state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Poll next state, interval/latency counters and the sample strobe.
   always_comb begin
      state_s   = state_r;
      div_cnt_s = div_cnt_r;
      lat_cnt_s = lat_cnt_r;
      sample_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!poll_en) begin
               div_cnt_s = '0;
            end else if (div_cnt_r == DIV_LAST) begin
               div_cnt_s = '0;
               state_s   = ST_REQ;
            end else begin
               div_cnt_s = div_cnt_r + DIV_ONE;
            end
         end
         ST_REQ: begin
            if (!bus.avm_waitrequest) begin
               lat_cnt_s = '0;
               state_s   = ST_WAIT;
            end else begin
               state_s   = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (lat_cnt_r == LAT_LAST) begin
               sample_s  = 1'b1;
               lat_cnt_s = '0;
               state_s   = ST_IDLE;
            end else begin
               lat_cnt_s = lat_cnt_r + LAT_ONE;
            end
         end
         default: begin
            state_s   = ST_IDLE;
            div_cnt_s = '0;
            lat_cnt_s = '0;
         end
      endcase
   end

   // Per-key debounce: a level is accepted after STABLE consecutive equal samples.
   always_comb begin
      cand_s = cand_r;
      stab_s = stab_r;
      deb_s  = deb_r;
      for (int i = 0; i < 4; i++) begin
         if (sample_s) begin
            if (bus.avm_readdata[i] == cand_r[i]) begin
               if (stab_r[i] == STABLE) begin
                  stab_s[i] = stab_r[i];
               end else begin
                  stab_s[i] = stab_r[i] + 4'd1;
               end
            end else begin
               cand_s[i] = bus.avm_readdata[i];
               stab_s[i] = 4'd1;
            end
            if (stab_s[i] == STABLE) begin
               deb_s[i] = cand_s[i];
            end else begin
               deb_s[i] = deb_r[i];
            end
         end else begin
            deb_s[i] = deb_r[i];
         end
      end
   end

   // Press detection, pending bookkeeping and FIFO push/pop decisions.
   always_comb begin
      press_s    = deb_r & ~deb_s;
      push_s     = (pending_r != 4'd0) && (fifo_cnt_r != FULL_CNT);
      push_idx_s = lowest_index(pending_r);
      if (push_s) begin
         push_mask_s = 4'd1 << push_idx_s;
      end else begin
         push_mask_s = 4'd0;
      end
      // A press on a bit still waiting (and not leaving this cycle) is lost.
      lost_s    = |(press_s & pending_r & ~push_mask_s);
      pending_s = (pending_r & ~push_mask_s) | press_s;
      pop_s     = (fifo_cnt_r != '0) && bus.evt_ready;
   end

   // Datapath registers: read strobe, debounce state, pending, overflow and FIFO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt_r   <= '0;
         lat_cnt_r   <= '0;
         avm_read_r  <= 1'b0;
         cand_r      <= 4'hF;
         stab_r      <= {4{STABLE}};
         deb_r       <= 4'hF;
         key_state_r <= 4'h0;
         pending_r   <= 4'h0;
         overflow_r  <= 1'b0;
         mem_r       <= '0;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         fifo_cnt_r  <= '0;
      end else begin
         div_cnt_r   <= div_cnt_s;
         lat_cnt_r   <= lat_cnt_s;
         avm_read_r  <= (state_s == ST_REQ);
         cand_r      <= cand_s;
         stab_r      <= stab_s;
         deb_r       <= deb_s;
         key_state_r <= ~deb_s;
         pending_r   <= pending_s;
         if (push_s) begin
            mem_r[wr_ptr_r] <= push_idx_s;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r        <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
            2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
            default: fifo_cnt_r <= fifo_cnt_r;
         endcase
         if (lost_s) begin
            overflow_r <= 1'b1;
         end else if (overflow_clr) begin
            overflow_r <= 1'b0;
         end else begin
            overflow_r <= overflow_r;
         end
      end
   end

   assign unused_bits_s   = ^bus.avm_readdata[31:4];
   assign bus.avm_address = 2'd0;
   assign bus.avm_read    = avm_read_r;
   assign bus.evt_valid   = (fifo_cnt_r != '0);
   assign bus.evt_key     = mem_r[rd_ptr_r];
   assign key_state       = key_state_r;
   assign overflow        = overflow_r;

endmodule

// File: tb/tb_digitallock_key_poller.sv
// Directed bench for digitallock_key_poller: expected key events go into a queue that a
// separate monitor drains whenever the DUT hands an event over.
module tb_digitallock_key_poller;
   logic       clk = 1'b0;
   logic       reset_n;
   logic       poll_en;
   logic       overflow_clr;
   logic [3:0] key_state;
   logic       overflow;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int hs_prev = -10;
   int hs_last = -10;
   logic [1:0] exp_q[$];
   logic [1:0] exp_key;

   digitallock_key_poller_if bus_if();

   digitallock_key_poller #(
      .POLL_DIV(8), .STABLE_POLLS(3), .FIFO_DEPTH(4), .READ_LATENCY(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .poll_en(poll_en), .bus(bus_if.master),
      .key_state(key_state), .overflow(overflow), .overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted event is compared against the head of the expected queue.
   always begin
      @(negedge clk);
      #1;
      if (reset_n === 1'b1 && bus_if.evt_valid === 1'b1 && bus_if.evt_ready === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL evt_unexpected: got key %0d expected none", bus_if.evt_key);
         end else begin
            exp_key = exp_q.pop_front();
            if (bus_if.evt_key !== exp_key) begin
               bad++;
               $display("FAIL evt_key: got %0d expected %0d", bus_if.evt_key, exp_key);
            end
         end
         hs_prev = hs_last;
         hs_last = cyc;
      end
   end

   // Counts rising edges until avm_read is seen high at a falling edge.
   task automatic wait_read(output int n);
      n = 0;
      while (bus_if.avm_read !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus_if.avm_read !== 1'b1) check("read_timeout", 32'(bus_if.avm_read), 32'd1);
   endtask

   // One complete read; pat is valid only in the latency cycle after acceptance.
   task automatic poll(input logic [3:0] pat, input int stall);
      int n;
      bus_if.avm_waitrequest = (stall > 0);
      wait_read(n);
      for (int i = 0; i < stall; i++) begin
         check("stall_read", 32'(bus_if.avm_read), 32'd1);
         check("stall_addr", 32'(bus_if.avm_address), 32'd0);
         @(negedge clk);
      end
      bus_if.avm_waitrequest = 1'b0;
      if (stall > 0) check("accept_read", 32'(bus_if.avm_read), 32'd1);
      @(negedge clk);
      bus_if.avm_readdata = {28'hFFFFFFF, pat};
      @(negedge clk);
      bus_if.avm_readdata = 32'hFFFFFFFF;
   endtask

   task automatic press_release(input logic [3:0] pat, input logic [3:0] ks);
      for (int i = 0; i < 3; i++) poll(pat, 0);
      check("press_state", 32'(key_state), 32'(ks));
      for (int i = 0; i < 3; i++) poll(4'hF, 0);
      check("release_state", 32'(key_state), 32'd0);
   endtask

   initial begin
      int n;
      reset_n = 1'b0;
      poll_en = 1'b0;
      overflow_clr = 1'b0;
      bus_if.avm_waitrequest = 1'b0;
      bus_if.avm_readdata = 32'hFFFFFFFF;
      bus_if.evt_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_read", 32'(bus_if.avm_read), 32'd0);
      check("rst_addr", 32'(bus_if.avm_address), 32'd0);
      check("rst_key_state", 32'(key_state), 32'd0);
      check("rst_evt_valid", 32'(bus_if.evt_valid), 32'd0);
      check("rst_evt_key", 32'(bus_if.evt_key), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);

      // Poll timing.
      reset_n = 1'b1;
      poll_en = 1'b1;
      wait_read(n);
      check("first_read_delay", 32'(n), 32'd8);
      check("read_addr", 32'(bus_if.avm_address), 32'd0);
      @(negedge clk);
      check("read_pulse_len", 32'(bus_if.avm_read), 32'd0);
      @(negedge clk);
      wait_read(n);
      check("read_interval", 32'(n), 32'd8);

      // Clean press of key 1, then release.
      poll(4'b1101, 0);
      check("t2_s1", 32'(key_state), 32'd0);
      poll(4'b1101, 0);
      check("t2_s2", 32'(key_state), 32'd0);
      exp_q.push_back(2'd1);
      poll(4'b1101, 0);
      check("t2_s3", 32'(key_state), 32'b0010);
      poll(4'hF, 0);
      poll(4'hF, 0);
      check("t2_rel2", 32'(key_state), 32'b0010);
      poll(4'hF, 0);
      check("t2_rel3", 32'(key_state), 32'd0);

      // Bounce: the stability count restarts on the glitch.
      poll(4'b1101, 0);
      poll(4'b1111, 0);
      poll(4'b1101, 0);
      poll(4'b1101, 0);
      check("t3_s4", 32'(key_state), 32'd0);
      exp_q.push_back(2'd1);
      poll(4'b1101, 0);
      check("t3_s5", 32'(key_state), 32'b0010);
      for (int i = 0; i < 3; i++) poll(4'hF, 0);
      check("t3_release", 32'(key_state), 32'd0);

      // Simultaneous press of keys 0 and 3.
      poll(4'b0110, 0);
      poll(4'b0110, 0);
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd3);
      poll(4'b0110, 0);
      check("t4_state", 32'(key_state), 32'b1001);
      repeat (5) @(negedge clk);
      check("t4_consecutive", 32'(hs_last - hs_prev), 32'd1);
      check("t4_drained", 32'(exp_q.size()), 32'd0);
      check("t4_no_pending", 32'(bus_if.evt_valid), 32'd0);
      for (int i = 0; i < 3; i++) poll(4'hF, 0);

      // FIFO full, one pending, one lost.
      bus_if.evt_ready = 1'b0;
      for (int p = 1; p <= 6; p++) begin
         if (p <= 5) exp_q.push_back(2'd2);
         press_release(4'b1011, 4'b0100);
         if (p == 5) check("t5_no_overflow_yet", 32'(overflow), 32'd0);
      end
      check("t5_overflow_set", 32'(overflow), 32'd1);
      check("t5_valid_full", 32'(bus_if.evt_valid), 32'd1);
      overflow_clr = 1'b1;
      @(negedge clk);
      overflow_clr = 1'b0;
      @(negedge clk);
      check("t5_overflow_clr", 32'(overflow), 32'd0);
      bus_if.evt_ready = 1'b1;
      repeat (12) @(negedge clk);
      check("t5_drained", 32'(exp_q.size()), 32'd0);
      check("t5_empty", 32'(bus_if.evt_valid), 32'd0);

      // Stalled reads: sample must come from the cycle after acceptance.
      poll(4'b0111, 5);
      poll(4'b0111, 5);
      exp_q.push_back(2'd3);
      poll(4'b0111, 5);
      check("t6_state", 32'(key_state), 32'b1000);
      for (int i = 0; i < 3; i++) poll(4'hF, 0);
      check("t6_release", 32'(key_state), 32'd0);

      // Reset during WAIT with events queued.
      bus_if.evt_ready = 1'b0;
      for (int i = 0; i < 3; i++) poll(4'b1100, 0);
      repeat (3) @(negedge clk);
      check("t7_queued", 32'(bus_if.evt_valid), 32'd1);
      wait_read(n);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("t7_rst_read", 32'(bus_if.avm_read), 32'd0);
      check("t7_rst_valid", 32'(bus_if.evt_valid), 32'd0);
      check("t7_rst_key_state", 32'(key_state), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      bus_if.evt_ready = 1'b1;
      wait_read(n);
      check("t7_read_delay", 32'(n), 32'd8);
      repeat (20) @(negedge clk);
      check("final_queue", 32'(exp_q.size()), 32'd0);
      check("final_valid", 32'(bus_if.evt_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/digitallock_key_poller.md
Name: digitallock_key_poller

Overview:
Avalon-MM master that polls the KEY PIO slave (read at address 0), debounces the four active-low push-buttons and queues one event per key press. It sits between the KEY PIO and the lock sequencing logic, which consumes key events through a ready/valid handshake. Processor polling of KEY is no longer required.

Parameters:
POLL_DIV, 50000, clock cycles between read issues; legal range is 4 or more.
STABLE_POLLS, 3, number of consecutive identical samples needed to accept a new key level; legal range is 1 to 15.
FIFO_DEPTH, 4, event FIFO depth; must be a power of 2 and at least 2.
READ_LATENCY, 1, cycles from read acceptance to valid readdata; fixed-latency slave.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
poll_en  in  1  enables polling
avm_address  out  2  slave address; constant 0
avm_read  out  1  read request
avm_waitrequest  in  1  slave stall; tie to 0 for the PIO
avm_readdata  in  32  slave data; only bits [3:0] are used (0 = pressed)
key_state  out  4  debounced level, 1 = pressed
evt_valid  out  1  FIFO head valid
evt_key  out  2  index of the pressed key at the FIFO head
evt_ready  in  1  consumer accepts the head
overflow  out  1  sticky flag: a press was lost
overflow_clr  in  1  clears overflow

Behaviour:
- Clock is clk. Reset is reset_n, asynchronous and active-low.
- Reset values:
  - avm_read=0, avm_address=0, key_state=0, evt_valid=0, evt_key=0, overflow=0.
  - FIFO empty, pending=0, state IDLE, interval and latency counters 0.
  - Per-bit candidate=1 and stability count=STABLE_POLLS, so every key starts as stable-released.
- Reset asserted mid-operation forces all of the above immediately. avm_read drops asynchronously.
- IDLE:
  - While poll_en=1, the interval counter increments. At POLL_DIV-1 the counter clears and the state goes to REQ.
  - While poll_en=0, the counter is held at 0.
- REQ:
  - avm_read=1, with avm_address held stable.
  - Stay in REQ while avm_waitrequest=1.
  - The cycle with waitrequest=0 is the acceptance cycle; go to WAIT.
- WAIT:
  - Count READ_LATENCY cycles after acceptance, then sample avm_readdata[3:0] and return to IDLE.
  - avm_read=0 in WAIT.
  - poll_en deasserting during REQ or WAIT does not abort; the transaction and its sample complete.
- Debounce, per bit, on each sample:
  - If the sample equals the candidate, the count increments, saturating at STABLE_POLLS.
  - Otherwise candidate=sample and count=1.
  - When count reaches STABLE_POLLS, the debounced bit takes the candidate value.
  - key_state = ~debounced, updated the cycle after the sample.
- Press edge:
  - A debounced bit going 1->0 sets the matching pending bit.
  - Release edges generate no event.
  - If a press edge occurs on a bit that is already pending, set overflow (the press is lost).
- Push:
  - Each cycle, if pending is nonzero and the FIFO is not full (based on the registered count), push the lowest set index and clear that pending bit.
  - One push per cycle at most.
- FIFO:
  - evt_valid = !empty; evt_key = head entry.
  - Pop when evt_valid && evt_ready.
  - Push and pop in the same cycle keeps the count unchanged.
  - A pop while full does not enable a push in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: overflow_clr clears it. If a set condition and overflow_clr occur in the same cycle, set wins.

Test Plan:
1. Reset, then poll_en=1, POLL_DIV=8, waitrequest=0 -> all outputs 0; first avm_read pulse 8 cycles after poll_en, lasting 1 cycle with address 0; the next read follows POLL_DIV cycles after return to IDLE.
2. readdata=4'b1101 for 3 polls, then 4'b1111 for 3 polls, STABLE_POLLS=3 -> key_state=4'b0010 after the 3rd sample; exactly one event with evt_key=1 (evt_ready=1); key_state returns to 0 after 3 released samples; no event on release.
3. Bounce sequence 1101,1111,1101,1101,1101 -> key_state stays 0 through the 4th sample and becomes 4'b0010 only after the 5th; exactly one event with evt_key=1.
4. Simultaneous press, readdata=4'b0110 stable, evt_ready=1 -> events evt_key=0 then evt_key=3 on consecutive cycles; pending=0 afterward.
5. evt_ready=0, FIFO_DEPTH=4, repeated press/release of KEY2 -> FIFO holds 4 events, the 5th press stays pending, the 6th press sets overflow=1; overflow_clr=1 clears it; evt_ready=1 drains 5 events, all with evt_key=2.
6. avm_waitrequest=1 for 5 cycles in REQ -> avm_read and address stay stable for 6 cycles; the sample is taken READ_LATENCY cycles after the waitrequest=0 cycle.
7. Assert reset_n=0 during WAIT with 2 events queued -> avm_read=0 and evt_valid=0 immediately; after release, the first read is issued POLL_DIV cycles later.
